camera_clock_sched: RTL and testbench

Trigger-synchronised scheduler for the camera output clock. It accepts a divide ratio and burst length through a valid/ready handshake, waits for a trigger rising edge, then emits exactly `burst_len` full periods of `cam_clk`. After the burst it reports done and returns to idle. It sits between the capture-control logic and the camera/TX pins, replacing a free-running divider with a gated, edge-aligned, countable clock.

---
 rtl/camera_pkg.sv | 14 +
 rtl/camera_clock_sched_if.sv | 16 +
 rtl/camera_edge_detect.sv | 23 ++
 rtl/camera_clock_sched.sv | 147 ++++++++++++++
 tb/tb_camera_clock_sched.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/camera_pkg.sv
// Shared types and default widths for the gated camera clock scheduler.
package camera_pkg;

  localparam int CAM_DIV_W = 8;
  localparam int CAM_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } cam_sched_state_t;

endpackage

// File: rtl/camera_clock_sched_if.sv
// Configuration handshake bundle: the capture controller offers a divide
// ratio and burst length, the scheduler accepts it while idle.
interface camera_clock_sched_if
  import camera_pkg::*;
#(
  parameter int DIV_W = CAM_DIV_W,
  parameter int CNT_W = CAM_CNT_W
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [DIV_W-1:0] cfg_div_half;
  logic [CNT_W-1:0] cfg_burst_len;

  modport master (output cfg_valid, output cfg_div_half, output cfg_burst_len, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_div_half, input cfg_burst_len, output cfg_ready);
endinterface

// File: rtl/camera_edge_detect.sv
// Rising-edge detector for a clock-synchronous strobe; rise is high in the
// cycle the input is first seen high.
module camera_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic strobe,
  output logic rise
);

  logic strobe_q;

  // previous-cycle sample of the strobe
  always_ff @(posedge clock) begin
    if (reset) begin
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= strobe;
    end
  end

  assign rise = strobe & ~strobe_q;

endmodule

// File: rtl/camera_clock_sched.sv
// Trigger-aligned camera clock: after a configuration is accepted, waits for
// a trigger edge and emits exactly burst_len 50 % duty periods of cam_clk.
module camera_clock_sched
  import camera_pkg::*;
#(
  parameter int DIV_W = CAM_DIV_W,
  parameter int CNT_W = CAM_CNT_W
) (
  input  logic                   clock,
  input  logic                   reset,
  camera_clock_sched_if.slave    cfg,
  input  logic                   trigger,
  input  logic                   abort,
  output logic                   cam_clk,
  output logic                   cam_clk_rise,
  output logic                   armed,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       periods,
  output logic                   trig_overrun
);

  cam_sched_state_t state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0] div_half_q, div_half_d;
  logic [CNT_W-1:0] burst_len_q, burst_len_d;
  logic [CNT_W-1:0] periods_q, periods_d;
  logic             cam_clk_q, cam_clk_d;
  logic             rise_q, rise_d;
  logic             overrun_q, overrun_d;
  logic             armed_q, busy_q, done_q;
  logic             trig_rise;

  camera_edge_detect u_trig_edge (
    .clock  (clock),
    .reset  (reset),
    .strobe (trigger),
    .rise   (trig_rise)
  );

  // next-state, divider and period counting
  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    div_half_d  = div_half_q;
    burst_len_d = burst_len_q;
    periods_d   = periods_q;
    cam_clk_d   = cam_clk_q;
    rise_d      = 1'b0;
    overrun_d   = trig_rise && ((state_q == RUN) || (state_q == DONE));

    if (abort) begin
      state_d   = IDLE;
      cam_clk_d = 1'b0;
      div_cnt_d = {DIV_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg.cfg_valid) begin
            state_d     = ARMED;
            div_half_d  = (cfg.cfg_div_half == {DIV_W{1'b0}}) ? DIV_W'(1) : cfg.cfg_div_half;
            burst_len_d = cfg.cfg_burst_len;
            periods_d   = {CNT_W{1'b0}};
          end else begin
            state_d = IDLE;
          end
        end
        ARMED: begin
          if (!trig_rise) begin
            state_d = ARMED;
          end else if (burst_len_q == {CNT_W{1'b0}}) begin
            state_d = DONE;
          end else begin
            state_d   = RUN;
            cam_clk_d = 1'b1;
            rise_d    = 1'b1;
            div_cnt_d = {DIV_W{1'b0}};
          end
        end
        RUN: begin
          if (div_cnt_q != (div_half_q - DIV_W'(1))) begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
          end else begin
            div_cnt_d = {DIV_W{1'b0}};
            // the completion check happens at the end of a low phase so the
            // final period keeps its full 50 % duty
            if (cam_clk_q) begin
              cam_clk_d = 1'b0;
              periods_d = periods_q + CNT_W'(1);
            end else if (periods_q == burst_len_q) begin
              state_d = DONE;
            end else begin
              cam_clk_d = 1'b1;
              rise_d    = 1'b1;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d   = IDLE;
          cam_clk_d = 1'b0;
        end
      endcase
    end
  end

  // state and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      div_cnt_q   <= {DIV_W{1'b0}};
      div_half_q  <= DIV_W'(1);
      burst_len_q <= {CNT_W{1'b0}};
      periods_q   <= {CNT_W{1'b0}};
      cam_clk_q   <= 1'b0;
      rise_q      <= 1'b0;
      overrun_q   <= 1'b0;
      armed_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      div_half_q  <= div_half_d;
      burst_len_q <= burst_len_d;
      periods_q   <= periods_d;
      cam_clk_q   <= cam_clk_d;
      rise_q      <= rise_d;
      overrun_q   <= overrun_d;
      armed_q     <= (state_d == ARMED);
      busy_q      <= (state_d == RUN) || (state_d == DONE);
      done_q      <= (state_d == DONE);
    end
  end

  assign cfg.cfg_ready  = (state_q == IDLE);
  assign cam_clk        = cam_clk_q;
  assign cam_clk_rise   = rise_q;
  assign armed          = armed_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign periods        = periods_q;
  assign trig_overrun   = overrun_q;

endmodule

// File: tb/tb_camera_clock_sched.sv
// Bench for camera_clock_sched: directed scenarios then random traffic, all
// compared cycle by cycle against an arithmetic model of the burst timeline.
module tb_camera_clock_sched;

  localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_DONE = 3;

  logic        clock = 1'b0;
  logic        rst_s, trig_s, abort_s;
  logic        cam_clk, cam_clk_rise, armed, busy, done, trig_overrun;
  logic [15:0] periods;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model state: mode, cycles since burst start, latched divide/length
  int m_mode = M_IDLE, m_k = 0, m_d = 1, m_n = 0, m_periods = 0;
  bit m_prev = 1'b0;
  bit e_clk = 0, e_rise = 0, e_done = 0, e_ov = 0;

  camera_clock_sched_if cfg_bus ();

  camera_clock_sched dut (
    .clock        (clock),
    .reset        (rst_s),
    .cfg          (cfg_bus.slave),
    .trigger      (trig_s),
    .abort        (abort_s),
    .cam_clk      (cam_clk),
    .cam_clk_rise (cam_clk_rise),
    .armed        (armed),
    .busy         (busy),
    .done         (done),
    .periods      (periods),
    .trig_overrun (trig_overrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit edge_s;
    int ph;
    edge_s = trig_s && !m_prev;
    if (rst_s) begin
      m_mode = M_IDLE; m_periods = 0; m_prev = 1'b0; e_ov = 1'b0;
    end else begin
      e_ov   = edge_s && (m_mode == M_RUN || m_mode == M_DONE);
      m_prev = trig_s;
      if (abort_s) begin
        m_mode = M_IDLE;
      end else begin
        case (m_mode)
          M_IDLE: if (cfg_bus.cfg_valid) begin
            m_d = (cfg_bus.cfg_div_half == 8'd0) ? 1 : int'(cfg_bus.cfg_div_half);
            m_n = int'(cfg_bus.cfg_burst_len);
            m_periods = 0;
            m_mode = M_ARMED;
          end
          M_ARMED: if (edge_s) begin
            if (m_n == 0) m_mode = M_DONE;
            else begin m_mode = M_RUN; m_k = 0; end
          end
          M_RUN: begin
            m_k++;
            if (m_k == 2 * m_d * m_n) m_mode = M_DONE;
          end
          default: m_mode = M_IDLE;
        endcase
      end
    end
    e_clk = 0; e_rise = 0; e_done = 0;
    if (m_mode == M_RUN) begin
      ph = m_k % (2 * m_d);
      e_clk = (ph < m_d);
      e_rise = (ph == 0);
      m_periods = m_k / (2 * m_d) + ((ph >= m_d) ? 1 : 0);
    end else if (m_mode == M_DONE) begin
      e_done = 1'b1;
      m_periods = m_n;
    end
  endtask

  // One cycle: compare outputs against the model, drive new inputs, step model.
  task automatic cycle(input bit r, input bit v, input int dv, input int ln, input bit t, input bit a);
    @(negedge clock);
    chk("cam_clk", 32'(cam_clk), 32'(e_clk));
    chk("cam_clk_rise", 32'(cam_clk_rise), 32'(e_rise));
    chk("done", 32'(done), 32'(e_done));
    chk("trig_overrun", 32'(trig_overrun), 32'(e_ov));
    chk("periods", 32'(periods), 32'(m_periods));
    chk("armed", 32'(armed), 32'(m_mode == M_ARMED));
    chk("busy", 32'(busy), 32'(m_mode == M_RUN || m_mode == M_DONE));
    chk("cfg_ready", 32'(cfg_bus.cfg_ready), 32'(m_mode == M_IDLE));
    rst_s = r; abort_s = a; trig_s = t;
    cfg_bus.cfg_valid = v;
    cfg_bus.cfg_div_half = 8'(dv);
    cfg_bus.cfg_burst_len = 16'(ln);
    model_step();
    cyc++;
  endtask

  task automatic quiet(input int n, input bit t);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 0, t, 1'b0);
  endtask

  initial begin
    bit t;
    rst_s = 1'b1; abort_s = 1'b0; trig_s = 1'b0;
    cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_div_half = 8'd0; cfg_bus.cfg_burst_len = 16'd0;
    repeat (3) @(posedge clock);
    rst_s = 1'b0;

    // basic burst div 3 / len 2
    cycle(1'b0, 1'b1, 3, 2, 1'b0, 1'b0);
    quiet(3, 1'b0);
    quiet(1, 1'b1);
    quiet(16, 1'b1);
    // fastest clock with zero divide
    cycle(1'b0, 1'b1, 0, 4, 1'b0, 1'b0);
    quiet(2, 1'b0);
    quiet(12, 1'b1);
    // zero-length burst
    cycle(1'b0, 1'b1, 5, 0, 1'b0, 1'b0);
    quiet(2, 1'b0);
    quiet(4, 1'b1);
    // abort in third high phase (k = 8)
    cycle(1'b0, 1'b1, 2, 5, 1'b0, 1'b0);
    quiet(1, 1'b0);
    quiet(9, 1'b1);
    cycle(1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
    quiet(3, 1'b0);
    // overrun plus a cfg offered mid-burst
    cycle(1'b0, 1'b1, 2, 3, 1'b0, 1'b0);
    quiet(1, 1'b0);
    quiet(4, 1'b1);
    quiet(2, 1'b0);
    cycle(1'b0, 1'b1, 7, 9, 1'b1, 1'b0);
    quiet(12, 1'b1);
    // reset mid-burst with trigger held high through release
    cycle(1'b0, 1'b1, 3, 4, 1'b0, 1'b0);
    quiet(1, 1'b0);
    quiet(6, 1'b1);
    cycle(1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
    quiet(2, 1'b1);
    cycle(1'b0, 1'b1, 2, 2, 1'b1, 1'b0);
    quiet(6, 1'b1);

    // random traffic
    t = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) t = ~t;
      cycle($urandom_range(0, 499) == 0, $urandom_range(0, 3) == 0,
            int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), t,
            $urandom_range(0, 199) == 0);
    end
    quiet(1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
